// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch stage and IF/ID register.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } fetch_state_t;

  localparam int REG_W   = 4;
  localparam int RN1_MSB = 7;
  localparam int RN1_LSB = 4;
  localparam int RN2_MSB = 3;
  localparam int RN2_LSB = 0;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // Saturating increment used by the optional performance counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      return value;
    end else begin
      return value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory req/ack bus between the fetch stage and instruction memory.
interface fetch_stage_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
) ();

  logic               req;
  logic [PC_W-1:0]    addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise contents are held.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic [PC_W-1:0]    d_pc,
  input  logic [INSTR_W-1:0] d_instr,
  output logic               valid,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr
);

  logic               valid_r;
  logic [PC_W-1:0]    pc_r;
  logic [INSTR_W-1:0] instr_r;

  // Pipeline register update; an invalid entry always carries a NOP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      pc_r    <= {PC_W{1'b0}};
      instr_r <= INSTR_W'(NOP_INSTR);
    end else if (flush) begin
      valid_r <= 1'b0;
      pc_r    <= {PC_W{1'b0}};
      instr_r <= INSTR_W'(NOP_INSTR);
    end else if (load) begin
      valid_r <= 1'b1;
      pc_r    <= d_pc;
      instr_r <= d_instr;
    end else begin
      valid_r <= valid_r;
      pc_r    <= pc_r;
      instr_r <= instr_r;
    end
  end

  assign valid = valid_r;
  assign pc    = pc_r;
  assign instr = instr_r;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, req/ack fetch FSM, one-entry hold buffer and IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds stall_cycles / fetch_count outputs.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
  parameter logic [PC_W-1:0] PC_STEP  = {{(PC_W-1){1'b0}}, 1'b1}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pc_write,
  input  logic               ifid_write,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  fetch_stage_if.master      imem,
  output logic               if_id_valid,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [REG_W-1:0]   if_id_rn1,
  output logic [REG_W-1:0]   if_id_rn2
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        fetch_count
`endif
);

  fetch_state_t       state_r;
  fetch_state_t       next_state_s;
  logic [PC_W-1:0]    pc_r;
  logic [PC_W-1:0]    pc_next_s;
  logic               req_r;
  logic [PC_W-1:0]    addr_r;
  logic               hold_valid_r;
  logic [PC_W-1:0]    hold_pc_r;
  logic [INSTR_W-1:0] hold_instr_r;

  logic               stall_s;
  logic               ifid_load_s;
  logic               ifid_clear_s;
  logic [PC_W-1:0]    ifid_d_pc_s;
  logic [INSTR_W-1:0] ifid_d_instr_s;
  logic               hold_capture_s;
  logic               hold_clear_s;

  assign stall_s = !pc_write || !ifid_write;

  // Next-state, PC and IF/ID control; a redirect outranks every stall.
  always_comb begin
    next_state_s   = state_r;
    pc_next_s      = pc_r;
    ifid_load_s    = 1'b0;
    ifid_d_pc_s    = pc_r;
    ifid_d_instr_s = imem.rdata;
    hold_capture_s = 1'b0;
    hold_clear_s   = 1'b0;
    case (state_r)
      IDLE: begin
        next_state_s = REQ;
        if (branch_taken) begin
          pc_next_s = branch_target;
        end else begin
          pc_next_s = pc_r;
        end
      end
      REQ: begin
        if (branch_taken) begin
          pc_next_s    = branch_target;
          hold_clear_s = 1'b1;
          next_state_s = imem.ack ? REQ : KILL;
        end else if (imem.ack && !stall_s) begin
          ifid_load_s = 1'b1;
          pc_next_s   = pc_r + PC_STEP;
        end else if (imem.ack) begin
          hold_capture_s = 1'b1;
          next_state_s   = HOLD;
        end else begin
          next_state_s = REQ;
        end
      end
      HOLD: begin
        ifid_d_pc_s    = hold_pc_r;
        ifid_d_instr_s = hold_instr_r;
        if (branch_taken) begin
          pc_next_s    = branch_target;
          hold_clear_s = 1'b1;
          next_state_s = REQ;
        end else if (!stall_s) begin
          ifid_load_s  = hold_valid_r;
          hold_clear_s = 1'b1;
          pc_next_s    = pc_r + PC_STEP;
          next_state_s = REQ;
        end else begin
          next_state_s = HOLD;
        end
      end
      KILL: begin
        if (branch_taken) begin
          pc_next_s    = branch_target;
          hold_clear_s = 1'b1;
          next_state_s = KILL;
        end else if (imem.ack) begin
          next_state_s = REQ;
        end else begin
          next_state_s = KILL;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // A free-running cycle with nothing fetched drops a bubble into IF/ID.
  assign ifid_clear_s = branch_taken || (!stall_s && !ifid_load_s);

  // State, PC and registered bus outputs; KILL keeps presenting the stale address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      req_r   <= 1'b0;
      addr_r  <= RESET_PC;
    end else begin
      state_r <= next_state_s;
      pc_r    <= pc_next_s;
      req_r   <= (next_state_s == REQ) || (next_state_s == KILL);
      addr_r  <= (next_state_s == KILL) ? addr_r : pc_next_s;
    end
  end

  // One-entry buffer for an instruction that arrived while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid_r <= 1'b0;
      hold_pc_r    <= {PC_W{1'b0}};
      hold_instr_r <= INSTR_W'(NOP_INSTR);
    end else if (hold_capture_s) begin
      hold_valid_r <= 1'b1;
      hold_pc_r    <= pc_r;
      hold_instr_r <= imem.rdata;
    end else if (hold_clear_s) begin
      hold_valid_r <= 1'b0;
      hold_pc_r    <= hold_pc_r;
      hold_instr_r <= hold_instr_r;
    end else begin
      hold_valid_r <= hold_valid_r;
      hold_pc_r    <= hold_pc_r;
      hold_instr_r <= hold_instr_r;
    end
  end

  assign imem.req  = req_r;
  assign imem.addr = addr_r;

  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ifid_load_s),
    .flush   (ifid_clear_s),
    .d_pc    (ifid_d_pc_s),
    .d_instr (ifid_d_instr_s),
    .valid   (if_id_valid),
    .pc      (if_id_pc),
    .instr   (if_id_instr)
  );

  // Register fields tap the registered instruction so the hazard unit sees no extra delay.
  assign if_id_rn1 = if_id_instr[RN1_MSB:RN1_LSB];
  assign if_id_rn2 = if_id_instr[RN2_MSB:RN2_LSB];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles_r;
  logic [31:0] fetch_count_r;

  // Saturating stall and fetch counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_r <= 32'd0;
      fetch_count_r  <= 32'd0;
    end else begin
      stall_cycles_r <= (stall_s && (state_r != IDLE)) ? sat_inc32(stall_cycles_r) : stall_cycles_r;
      fetch_count_r  <= ifid_load_s ? sat_inc32(fetch_count_r) : fetch_count_r;
    end
  end

  assign stall_cycles = stall_cycles_r;
  assign fetch_count  = fetch_count_r;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; memory data is addr + 0x1230.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        rst2_n;
  logic        pc_write;
  logic        ifid_write;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        ack_auto;
  logic        ack_man;

  logic        if_id_valid;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_instr;
  logic [3:0]  if_id_rn1;
  logic [3:0]  if_id_rn2;

  logic        w_valid;
  logic [15:0] w_pc;
  logic [15:0] w_instr;
  logic [3:0]  w_rn1;
  logic [3:0]  w_rn2;

  int n_cmp;
  int n_bad;

  fetch_stage_if #(.PC_W(16), .INSTR_W(16)) bus ();
  fetch_stage_if #(.PC_W(16), .INSTR_W(16)) bus2 ();

  assign bus.ack    = ack_auto ? bus.req : ack_man;
  assign bus.rdata  = bus.addr + 16'h1230;
  assign bus2.ack   = bus2.req;
  assign bus2.rdata = bus2.addr + 16'h1230;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] fetch_count;
  logic [31:0] stall_cycles2;
  logic [31:0] fetch_count2;
`endif

  fetch_stage #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .PC_STEP(16'h0001)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (bus),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_rn1     (if_id_rn1),
    .if_id_rn2     (if_id_rn2)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles  (stall_cycles),
    .fetch_count   (fetch_count)
`endif
  );

  fetch_stage #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'hFFFE), .PC_STEP(16'h0001)) dut_wrap (
    .clk           (clk),
    .rst_n         (rst2_n),
    .pc_write      (1'b1),
    .ifid_write    (1'b1),
    .branch_taken  (1'b0),
    .branch_target (16'h0000),
    .imem          (bus2),
    .if_id_valid   (w_valid),
    .if_id_pc      (w_pc),
    .if_id_instr   (w_instr),
    .if_id_rn1     (w_rn1),
    .if_id_rn2     (w_rn2)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles  (stall_cycles2),
    .fetch_count   (fetch_count2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%0b exp=0", bus.req); end
    n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b exp=0", if_id_valid); end
    n_cmp++; if (if_id_instr !== 16'h0000) begin n_bad++; $display("FAIL reset_instr got=%h exp=0000", if_id_instr); end
    n_cmp++; if (if_id_pc !== 16'h0000) begin n_bad++; $display("FAIL reset_pc got=%h exp=0000", if_id_pc); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 16'h0000) begin n_bad++; $display("FAIL first_req got=%0b/%h exp=1/0000", bus.req, bus.addr); end
    n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL bubble_after_reset got=%0b exp=0", if_id_valid); end
  endtask

  task automatic test_free_run();
    logic [15:0] exp;
    for (int i = 0; i < 4; i++) begin
      step();
      exp = 16'h1230 + 16'(i);
      n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'(i)) begin n_bad++; $display("FAIL free_run_pc%0d got=%0b/%h exp=1/%h", i, if_id_valid, if_id_pc, 16'(i)); end
      n_cmp++; if (if_id_instr !== exp) begin n_bad++; $display("FAIL free_run_instr%0d got=%h exp=%h", i, if_id_instr, exp); end
      n_cmp++; if (if_id_rn1 !== exp[7:4] || if_id_rn2 !== exp[3:0]) begin n_bad++; $display("FAIL free_run_rn%0d got=%h/%h exp=%h/%h", i, if_id_rn1, if_id_rn2, exp[7:4], exp[3:0]); end
    end
  endtask

  task automatic test_load_use();
    step();
    n_cmp++; if (if_id_pc !== 16'h0004 || bus.addr !== 16'h0005) begin n_bad++; $display("FAIL pre_stall got=%h/%h exp=0004/0005", if_id_pc, bus.addr); end
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL stall_req%0d got=%0b exp=0", i, bus.req); end
      n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'h0004 || if_id_instr !== 16'h1234) begin n_bad++; $display("FAIL stall_frozen%0d got=%0b/%h/%h exp=1/0004/1234", i, if_id_valid, if_id_pc, if_id_instr); end
    end
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    step();
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'h0005 || if_id_instr !== 16'h1235) begin n_bad++; $display("FAIL release_ifid got=%0b/%h/%h exp=1/0005/1235", if_id_valid, if_id_pc, if_id_instr); end
    n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 16'h0006) begin n_bad++; $display("FAIL release_addr got=%0b/%h exp=1/0006", bus.req, bus.addr); end
    step();
    n_cmp++; if (if_id_pc !== 16'h0006 || if_id_instr !== 16'h1236) begin n_bad++; $display("FAIL after_release got=%h/%h exp=0006/1236", if_id_pc, if_id_instr); end
  endtask

  task automatic test_branch_in_stall();
    pc_write      = 1'b0;
    ifid_write    = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 16'h0040;
    step();
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== 16'h0000) begin n_bad++; $display("FAIL br_stall_flush got=%0b/%h exp=0/0000", if_id_valid, if_id_instr); end
    n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 16'h0040) begin n_bad++; $display("FAIL br_stall_addr got=%0b/%h exp=1/0040", bus.req, bus.addr); end
    branch_taken = 1'b0;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    step();
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'h0040 || if_id_instr !== 16'h1270) begin n_bad++; $display("FAIL br_target_fetch got=%0b/%h/%h exp=1/0040/1270", if_id_valid, if_id_pc, if_id_instr); end
  endtask

  task automatic test_redirect_kill();
    branch_taken  = 1'b1;
    branch_target = 16'h0008;
    step();
    n_cmp++; if (bus.addr !== 16'h0008) begin n_bad++; $display("FAIL kill_setup got=%h exp=0008", bus.addr); end
    branch_taken = 1'b0;
    ack_auto     = 1'b0;
    ack_man      = 1'b0;
    step();
    n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 16'h0008 || if_id_valid !== 1'b0) begin n_bad++; $display("FAIL wait_ack got=%0b/%h/%0b exp=1/0008/0", bus.req, bus.addr, if_id_valid); end
    branch_taken  = 1'b1;
    branch_target = 16'h0100;
    step();
    n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 16'h0008) begin n_bad++; $display("FAIL kill_stale_addr got=%0b/%h exp=1/0008", bus.req, bus.addr); end
    branch_taken = 1'b0;
    step();
    n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 16'h0008) begin n_bad++; $display("FAIL kill_hold_addr got=%0b/%h exp=1/0008", bus.req, bus.addr); end
    ack_man = 1'b1;
    step();
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== 16'h0000) begin n_bad++; $display("FAIL kill_discard got=%0b/%h exp=0/0000", if_id_valid, if_id_instr); end
    n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 16'h0100) begin n_bad++; $display("FAIL kill_new_addr got=%0b/%h exp=1/0100", bus.req, bus.addr); end
    ack_man  = 1'b0;
    ack_auto = 1'b1;
    step();
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'h0100 || if_id_instr !== 16'h1330) begin n_bad++; $display("FAIL kill_target_fetch got=%0b/%h/%h exp=1/0100/1330", if_id_valid, if_id_pc, if_id_instr); end
  endtask

  task automatic test_wrap();
    rst2_n = 1'b0;
    step();
    rst2_n = 1'b1;
    step();
    n_cmp++; if (bus2.req !== 1'b1 || bus2.addr !== 16'hFFFE) begin n_bad++; $display("FAIL wrap_addr0 got=%0b/%h exp=1/fffe", bus2.req, bus2.addr); end
    step();
    n_cmp++; if (bus2.addr !== 16'hFFFF || w_pc !== 16'hFFFE || w_instr !== 16'h122E) begin n_bad++; $display("FAIL wrap_addr1 got=%h/%h/%h exp=ffff/fffe/122e", bus2.addr, w_pc, w_instr); end
    step();
    n_cmp++; if (bus2.addr !== 16'h0000 || w_pc !== 16'hFFFF || w_instr !== 16'h122F) begin n_bad++; $display("FAIL wrap_addr2 got=%h/%h/%h exp=0000/ffff/122f", bus2.addr, w_pc, w_instr); end
    step();
    n_cmp++; if (w_valid !== 1'b1 || w_pc !== 16'h0000 || w_instr !== 16'h1230) begin n_bad++; $display("FAIL wrap_fetch got=%0b/%h/%h exp=1/0000/1230", w_valid, w_pc, w_instr); end
  endtask

  task automatic test_reset_mid_req();
    ack_auto = 1'b0;
    ack_man  = 1'b0;
    step();
    n_cmp++; if (bus.req !== 1'b1) begin n_bad++; $display("FAIL mid_req_pending got=%0b exp=1", bus.req); end
    rst_n = 1'b0;
    step();
    n_cmp++; if (bus.req !== 1'b0 || if_id_valid !== 1'b0 || if_id_pc !== 16'h0000 || if_id_instr !== 16'h0000) begin n_bad++; $display("FAIL mid_req_reset got=%0b/%0b/%h/%h exp=0/0/0000/0000", bus.req, if_id_valid, if_id_pc, if_id_instr); end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++; if (stall_cycles !== 32'd0 || fetch_count !== 32'd0) begin n_bad++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", stall_cycles, fetch_count); end
`endif
    ack_man = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 16'h0000 || if_id_valid !== 1'b0) begin n_bad++; $display("FAIL late_ack_ignored got=%0b/%h/%0b exp=1/0000/0", bus.req, bus.addr, if_id_valid); end
    step();
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'h0000 || if_id_instr !== 16'h1230) begin n_bad++; $display("FAIL restart_fetch got=%0b/%h/%h exp=1/0000/1230", if_id_valid, if_id_pc, if_id_instr); end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++; if (stall_cycles !== 32'd0 || fetch_count !== 32'd1) begin n_bad++; $display("FAIL perf_count got=%0d/%0d exp=0/1", stall_cycles, fetch_count); end
`endif
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    rst_n         = 1'b0;
    rst2_n        = 1'b0;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    ack_auto      = 1'b1;
    ack_man       = 1'b0;
    test_reset();
    test_free_run();
    test_load_use();
    test_branch_in_stall();
    test_redirect_kill();
    test_wrap();
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached=%0t limit=100000", $time);
    $fatal(1, "timeout");
  end

endmodule
